bcd_to_bin_converter: RTL
=========================

Name: bcd_to_bin_converter

Overview:
- Sequential 4-digit packed-BCD to binary converter, the inverse of the combinational binary-to-BCD unit in the display path.
- Converts keypad/switch decimal entry (thousands/hundreds/tens/ones) into a 13-bit binary operand for the pipelined computer's I/O port.
- Uses reverse double-dabble: one shift-right plus per-digit subtract-3 correction per clock, with a start/busy/done handshake.

Parameters:
- BIN_WIDTH, 13, width of the bin output; the value is truncated to this width and any excess is flagged on overflow.
- ITERATIONS, 14, number of shift iterations, which is also the internal binary register width. It must hold 9999, and must be at least BIN_WIDTH+1 for overflow detection.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request conversion; sampled only in IDLE
- thousands  input  4  BCD digit 3
- hundreds  input  4  BCD digit 2
- tens  input  4  BCD digit 1
- ones  input  4  BCD digit 0
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse; results valid from this cycle on
- bin  output  BIN_WIDTH  converted value, low BIN_WIDTH bits
- overflow  output  1  converted value exceeds 2^BIN_WIDTH-1
- error  output  1  an input digit was greater than 9

Behaviour:
- Reset is the only asynchronous path and is honoured at any time, including mid-conversion:
  - state to IDLE, iteration counter to 0, internal registers to 0;
  - busy, done, bin, overflow and error all go to 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=0: remain in IDLE.
  - start=1 at rising edge k: latch {thousands,hundreds,tens,ones} into a 16-bit BCD register; clear the ITERATIONS-bit binary register and the counter.
  - If any latched digit is greater than 9: go to DONE and skip SHIFT.
  - Otherwise: go to SHIFT.
- SHIFT, one iteration per edge:
  - Shift the concatenation {bcd, binreg} right by 1; the bcd MSB is filled with 0.
  - Then, for each of the 4 nibbles of the shifted bcd value: if the nibble is 8 or more, subtract 3 from it.
  - Both steps complete in the same cycle.
  - Increment the counter; after iteration ITERATIONS (counter == ITERATIONS-1), go to DONE.
- DONE, lasting exactly one cycle:
  - done=1 and busy=0.
  - Next state is IDLE unconditionally.
- Output registers (bin, overflow, error) load on the same edge that enters DONE:
  - Valid conversion: bin = binreg[BIN_WIDTH-1:0]; overflow = OR of binreg[ITERATIONS-1:BIN_WIDTH]; error = 0.
  - Invalid digit: bin = 0, overflow = 0, error = 1.
  - These outputs then hold until the next DONE entry or reset.
- Timing:
  - busy = (state == SHIFT); it is high for the ITERATIONS cycles following edge k.
  - Valid input: done is high in the cycle after edge k+ITERATIONS, i.e. latency 14 cycles from the start-sampling edge to done observed (default).
  - Invalid input: done is high in the cycle after edge k (latency 1).
- start handling:
  - start while in SHIFT or DONE is ignored and is not queued.
  - A start held high continuously retriggers on the first IDLE cycle after DONE, so back-to-back throughput is ITERATIONS+2 cycles.
- Digit inputs are sampled only at the start edge; changes during SHIFT have no effect.
- All arithmetic is unsigned. At the end of a valid conversion the bcd register is always 0; this is not checked in RTL and may be asserted in simulation.

Test Plan:
- Reset, then start with digits 1,2,3,4 -> busy high for 14 cycles; done pulses in the cycle after edge k+14; bin=1234, overflow=0, error=0.
- Digits 8,1,9,1 and 0,0,0,0 -> bin=8191 with overflow=0; bin=0 with overflow=0. Both latencies are 14.
- Digits 9,9,9,9 -> overflow=1, bin=1807 (9999 mod 8192). Digits 8,1,9,2 -> overflow=1, bin=0.
- Digits 1,2,0xA,4 -> done in the cycle after the start edge, error=1, bin=0, busy never asserted. A following valid 0,0,0,5 conversion -> error cleared, bin=5.
- Pulse start again 3 cycles into a 1234 conversion with digits changed to 9,9,9,9 -> ignored; the result is still 1234 at the original done time. start held high continuously -> conversions repeat every 16 cycles.
- Assert reset asynchronously (between clock edges) at iteration 7 -> busy, done, bin, overflow and error go to 0 immediately. No done pulse appears after reset is released until a new start is given.

Source files
------------

// File: rtl/bcd_to_bin_converter.sv
// Sequential 4-digit packed-BCD to binary converter (reverse double-dabble).
// Each SHIFT cycle does one right shift of {bcd, bin} and then the per-nibble -3 fix-up.
module bcd_to_bin_converter #(
  parameter int unsigned BIN_WIDTH  = 13,
  parameter int unsigned ITERATIONS = 14
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           thousands,
  input  logic [3:0]           hundreds,
  input  logic [3:0]           tens,
  input  logic [3:0]           ones,
  output logic                 busy,
  output logic                 done,
  output logic [BIN_WIDTH-1:0] bin,
  output logic                 overflow,
  output logic                 error
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int unsigned       CNT_W    = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ITERATIONS - 1);

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [15:0]           r_bcd;
  logic [ITERATIONS-1:0] r_binreg;
  logic [BIN_WIDTH-1:0]  r_bin;
  logic                  r_overflow;
  logic                  r_error;

  logic                  w_bad_digit;
  logic [15:0]           w_bcd_next;
  logic [ITERATIONS-1:0] w_bin_next;

  assign w_bad_digit = (thousands > 4'd9) || (hundreds > 4'd9) ||
                       (tens > 4'd9) || (ones > 4'd9);

  // Shift first, then correct every nibble that came out at 8 or above.
  always_comb begin
    logic [15:0] w_bcd_sh;
    {w_bcd_sh, w_bin_next} = {1'b0, r_bcd, r_binreg[ITERATIONS-1:1]};
    w_bcd_next = w_bcd_sh;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_bcd_sh[4*i+3]) begin
        w_bcd_next[4*i +: 4] = w_bcd_sh[4*i +: 4] - 4'd3;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bcd      <= '0;
      r_binreg   <= '0;
      r_bin      <= '0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bcd    <= {thousands, hundreds, tens, ones};
            r_binreg <= '0;
            r_cnt    <= '0;
            if (w_bad_digit) begin
              r_state    <= S_DONE;
              r_bin      <= '0;
              r_overflow <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_bcd    <= w_bcd_next;
          r_binreg <= w_bin_next;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state    <= S_DONE;
            r_bin      <= w_bin_next[BIN_WIDTH-1:0];
            r_overflow <= |w_bin_next[ITERATIONS-1:BIN_WIDTH];
            r_error    <= 1'b0;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == S_SHIFT);
  assign done     = (r_state == S_DONE);
  assign bin      = r_bin;
  assign overflow = r_overflow;
  assign error    = r_error;

endmodule
